// File: rtl/asteroid_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : asteroid_spawn_scheduler
// Purpose  : Arms asteroid slots once per spawn gap, assigns each a free lane
//            and ramps the difficulty level as successful spawns accumulate.
// Revision : 1.0 - initial release
// ============================================================================
module asteroid_spawn_scheduler #(
    parameter int NUM_SLOTS     = 3,
    parameter int GAP_INIT      = 60,
    parameter int GAP_MIN       = 16,
    parameter int GAP_STEP      = 4,
    parameter int SPEEDUP_EVERY = 8,
    parameter int LANE_BASE     = 40,
    parameter int LANE_PITCH    = 72
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    halt,
    input  logic [4:0]              rand_val,
    input  logic [NUM_SLOTS-1:0]    slot_done,
    output logic [NUM_SLOTS-1:0]    spawn,
    output logic [NUM_SLOTS-1:0]    active,
    output logic [10*NUM_SLOTS-1:0] lane_x,
    output logic [1:0]              level,
    output logic                    busy_full
);

    localparam int c_GAP_W  = $clog2(GAP_INIT + GAP_MIN + GAP_STEP + 1);
    localparam int c_SPC_W  = $clog2(SPEEDUP_EVERY + 1);
    localparam int c_SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [c_GAP_W-1:0] c_GAP_INIT  = c_GAP_W'(GAP_INIT);
    localparam logic [c_GAP_W-1:0] c_GAP_MIN   = c_GAP_W'(GAP_MIN);
    localparam logic [c_GAP_W-1:0] c_GAP_STEP  = c_GAP_W'(GAP_STEP);
    localparam logic [c_GAP_W-1:0] c_GAP_FLOOR = c_GAP_W'(GAP_MIN + GAP_STEP);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE   = c_GAP_W'(1);
    localparam logic [c_SPC_W-1:0] c_SPC_LAST  = c_SPC_W'(SPEEDUP_EVERY - 1);
    localparam logic [c_SPC_W-1:0] c_SPC_ONE   = c_SPC_W'(1);
    localparam logic [9:0]         c_LANE_BASE  = 10'(LANE_BASE);
    localparam logic [9:0]         c_LANE_PITCH = 10'(LANE_PITCH);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_WAIT  = 3'd1;
    localparam logic [2:0] c_ST_PICK  = 3'd2;
    localparam logic [2:0] c_ST_LANE  = 3'd3;
    localparam logic [2:0] c_ST_ISSUE = 3'd4;

    logic [2:0]                r_state;
    logic [c_GAP_W-1:0]        r_gap;
    logic [c_GAP_W-1:0]        r_gap_cnt;
    logic [c_SPC_W-1:0]        r_spawn_cnt;
    logic [1:0]                r_level;
    logic [c_SLOT_W-1:0]       r_slot;
    logic [2:0]                r_cand;
    logic [NUM_SLOTS-1:0]      r_active;
    logic [NUM_SLOTS-1:0]      r_spawn;
    logic                      r_busy_full;
    logic [NUM_SLOTS-1:0][9:0] r_lane_x;
    logic [NUM_SLOTS-1:0][2:0] r_lane_idx;

    logic                      w_free_found;
    logic [c_SLOT_W-1:0]       w_free_idx;
    logic [NUM_SLOTS-1:0]      w_slot_mask;
    logic [NUM_SLOTS-1:0]      w_lane_hit;
    logic                      w_conflict;
    logic                      w_issue;
    logic [NUM_SLOTS-1:0]      w_active_nxt;
    logic [9:0]                w_lane_x;
    logic                      w_unused_rand;

    assign w_unused_rand = ^rand_val[4:3];

    generate
        for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
            // Lanes are compared by index, never by pixel position.
            assign w_lane_hit[g]      = r_active[g] && (r_lane_idx[g] == r_cand);
            assign w_slot_mask[g]     = (r_slot == c_SLOT_W'(g));
            assign lane_x[10*g +: 10] = r_lane_x[g];
        end
    endgenerate

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_SLOT_W'(i);
            end
        end
    end

    assign w_conflict   = |w_lane_hit;
    assign w_issue      = (r_state == c_ST_ISSUE) && !halt;
    assign w_lane_x     = c_LANE_BASE + c_LANE_PITCH * {7'd0, r_cand};
    // Slot returns are honoured even while halted; the issued slot was free.
    assign w_active_nxt = (r_active & ~slot_done) | (w_issue ? w_slot_mask : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_gap       <= c_GAP_INIT;
            r_gap_cnt   <= '0;
            r_spawn_cnt <= '0;
            r_level     <= 2'd0;
            r_slot      <= '0;
            r_cand      <= 3'd0;
            r_active    <= '0;
            r_spawn     <= '0;
            r_busy_full <= 1'b0;
            r_lane_x    <= '0;
            r_lane_idx  <= '0;
        end else begin
            r_active    <= w_active_nxt;
            r_busy_full <= &w_active_nxt;
            r_spawn     <= w_issue ? w_slot_mask : '0;
            if (!halt) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (frame_tick) begin
                            r_state <= c_ST_WAIT;
                        end
                    end
                    c_ST_WAIT: begin
                        if (frame_tick) begin
                            if (r_gap_cnt == r_gap - c_GAP_ONE) begin
                                r_gap_cnt <= '0;
                                r_state   <= c_ST_PICK;
                            end else begin
                                r_gap_cnt <= r_gap_cnt + c_GAP_ONE;
                            end
                        end
                    end
                    c_ST_PICK: begin
                        if (!w_free_found) begin
                            // Retry on the very next frame tick.
                            r_gap_cnt <= r_gap - c_GAP_ONE;
                            r_state   <= c_ST_WAIT;
                        end else begin
                            r_slot  <= w_free_idx;
                            r_cand  <= rand_val[2:0];
                            r_state <= c_ST_LANE;
                        end
                    end
                    c_ST_LANE: begin
                        if (w_conflict) begin
                            r_cand <= r_cand + 3'd1;
                        end else begin
                            r_state <= c_ST_ISSUE;
                        end
                    end
                    c_ST_ISSUE: begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (w_slot_mask[i]) begin
                                r_lane_x[i]   <= w_lane_x;
                                r_lane_idx[i] <= r_cand;
                            end
                        end
                        // gap_cnt is always zero here, so the gap may change now.
                        if (r_spawn_cnt == c_SPC_LAST) begin
                            r_spawn_cnt <= '0;
                            r_gap       <= (r_gap >= c_GAP_FLOOR) ? (r_gap - c_GAP_STEP) : c_GAP_MIN;
                            if (r_level != 2'd3) begin
                                r_level <= r_level + 2'd1;
                            end
                        end else begin
                            r_spawn_cnt <= r_spawn_cnt + c_SPC_ONE;
                        end
                        r_state <= c_ST_WAIT;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign spawn     = r_spawn;
    assign active    = r_active;
    assign level     = r_level;
    assign busy_full = r_busy_full;

endmodule
`default_nettype wire

// File: tb/tb_asteroid_spawn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_asteroid_spawn_scheduler
// Purpose  : Directed self-checking bench for asteroid_spawn_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asteroid_spawn_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        halt;
    logic [4:0]  rand_val;
    logic [2:0]  slot_done;
    logic [2:0]  spawn;
    logic [2:0]  active;
    logic [29:0] lane_x;
    logic [1:0]  level;
    logic        busy_full;

    int n_assert = 0;
    int n_fail   = 0;
    int t_ticks, t_lat, t_pulses, q;
    logic [2:0] t_sp;
    int gap_m, lvl_m;

    asteroid_spawn_scheduler #(
        .NUM_SLOTS(3), .GAP_INIT(60), .GAP_MIN(16), .GAP_STEP(4),
        .SPEEDUP_EVERY(8), .LANE_BASE(40), .LANE_PITCH(72)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .halt(halt),
        .rand_val(rand_val), .slot_done(slot_done), .spawn(spawn),
        .active(active), .lane_x(lane_x), .level(level), .busy_full(busy_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_done(input logic [2:0] m);
        slot_done = m;
        step();
        slot_done = '0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Ticks spaced 7 cycles apart; counts spawn pulses seen in between.
    task automatic ticks_quiet(input int n, output int spawns);
        spawns = 0;
        for (int t = 0; t < n; t++) begin
            pulse_tick();
            for (int c = 0; c < 6; c++) begin
                step();
                if (spawn != '0) spawns++;
            end
        end
    endtask

    // Latency counts clock edges after the edge that captured the tick.
    task automatic tick_until_spawn(output int nticks, output int lat,
                                    output int pulses, output logic [2:0] sp);
        nticks = -1;
        lat    = -1;
        pulses = 0;
        sp     = '0;
        for (int t = 1; t <= 200 && nticks < 0; t++) begin
            pulse_tick();
            for (int c = 1; c <= 6; c++) begin
                step();
                if (spawn != '0) begin
                    pulses++;
                    if (nticks < 0) begin
                        nticks = t;
                        lat    = c;
                        sp     = spawn;
                    end
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        halt       = 1'b0;
        rand_val   = 5'd0;
        slot_done  = 3'b000;
        reset_dut();

        check("rst_spawn",  32'(spawn), 0);
        check("rst_active", 32'(active), 0);
        check("rst_lane_x", lane_x, 0);
        check("rst_level",  32'(level), 0);
        check("rst_busy",   32'(busy_full), 0);

        // First spawn: IDLE tick plus 60 gap ticks, lane 3
        rand_val = 5'd3;
        tick_until_spawn(t_ticks, t_lat, t_pulses, t_sp);
        check("s1_ticks",  t_ticks, 61);
        check("s1_lat",    t_lat, 3);
        check("s1_pulses", t_pulses, 1);
        check("s1_slot",   32'(t_sp), 32'h1);
        check("s1_active", 32'(active), 32'h1);
        check("s1_x0",     32'(lane_x[9:0]), 256);

        // One lane conflict: 3 -> 4
        tick_until_spawn(t_ticks, t_lat, t_pulses, t_sp);
        check("s2_ticks", t_ticks, 60);
        check("s2_lat",   t_lat, 4);
        check("s2_slot",  32'(t_sp), 32'h2);
        check("s2_x1",    32'(lane_x[19:10]), 328);

        // Two conflicts: 3 -> 4 -> 5
        tick_until_spawn(t_ticks, t_lat, t_pulses, t_sp);
        check("s3_lat",  t_lat, 5);
        check("s3_slot", 32'(t_sp), 32'h4);
        check("s3_x2",   32'(lane_x[29:20]), 400);
        check("s3_busy", 32'(busy_full), 1);

        pulse_done(3'b001);
        check("done0_active", 32'(active), 32'h6);
        check("done0_busy",   32'(busy_full), 0);

        // Busy lanes 4,5 with seed 4 -> lane 6
        rand_val = 5'd4;
        tick_until_spawn(t_ticks, t_lat, t_pulses, t_sp);
        check("s4_ticks", t_ticks, 60);
        check("s4_lat",   t_lat, 5);
        check("s4_slot",  32'(t_sp), 32'h1);
        check("s4_x0",    32'(lane_x[9:0]), 472);

        // All slots busy at the due tick: no spawn, retry next tick
        rand_val = 5'd0;
        ticks_quiet(60, q);
        check("full_nospawn", q, 0);
        check("full_busy",    32'(busy_full), 1);
        pulse_done(3'b010);
        check("done1_active", 32'(active), 32'h5);
        tick_until_spawn(t_ticks, t_lat, t_pulses, t_sp);
        check("retry_ticks", t_ticks, 1);
        check("retry_lat",   t_lat, 3);
        check("retry_slot",  32'(t_sp), 32'h2);
        check("retry_x1",    32'(lane_x[19:10]), 40);

        // Halt while in LANE
        reset_dut();
        rand_val = 5'd3;
        tick_until_spawn(t_ticks, t_lat, t_pulses, t_sp);
        check("h_pre_ticks", t_ticks, 61);
        rand_val = 5'd0;
        ticks_quiet(59, q);
        check("h_pre_quiet", q, 0);
        pulse_tick();
        step();
        halt = 1'b1;
        ticks_quiet(100, q);
        check("h_no_spawn", q, 0);
        pulse_done(3'b001);
        check("h_done_clears", 32'(active), 0);
        halt = 1'b0;
        step();
        check("h_rel_lane", 32'(spawn), 0);
        step();
        check("h_rel_issue",  32'(spawn), 32'h2);
        check("h_rel_active", 32'(active), 32'h2);
        check("h_rel_x1",     32'(lane_x[19:10]), 40);
        rand_val = 5'd2;
        tick_until_spawn(t_ticks, t_lat, t_pulses, t_sp);
        check("h_post_ticks", t_ticks, 60);
        check("h_post_slot",  32'(t_sp), 32'h1);
        check("h_post_x0",    32'(lane_x[9:0]), 184);

        // Reset together with halt during ISSUE
        rand_val = 5'd5;
        ticks_quiet(59, q);
        check("r_pre_quiet", q, 0);
        pulse_tick();
        step();
        step();
        reset = 1'b1;
        halt  = 1'b1;
        step();
        check("r_spawn",  32'(spawn), 0);
        check("r_active", 32'(active), 0);
        check("r_lane_x", lane_x, 0);
        check("r_level",  32'(level), 0);
        check("r_busy",   32'(busy_full), 0);
        reset = 1'b0;
        halt  = 1'b0;
        rand_val = 5'd1;
        tick_until_spawn(t_ticks, t_lat, t_pulses, t_sp);
        check("r_post_ticks", t_ticks, 61);
        check("r_post_slot",  32'(t_sp), 32'h1);
        check("r_post_x0",    32'(lane_x[9:0]), 112);

        // Difficulty ramp; upper rand bits vary and must be ignored
        reset_dut();
        gap_m = 60;
        lvl_m = 0;
        for (int k = 1; k <= 96; k++) begin
            rand_val = 5'((k * 9) % 32);
            tick_until_spawn(t_ticks, t_lat, t_pulses, t_sp);
            check("d_ticks", t_ticks, (k == 1) ? 61 : gap_m);
            if (k % 8 == 0) begin
                gap_m = (gap_m - 4 < 16) ? 16 : gap_m - 4;
                if (lvl_m < 3) lvl_m++;
            end
            check("d_level", 32'(level), lvl_m);
            check("d_x0", 32'(lane_x[9:0]), 40 + 72 * (k % 8));
            pulse_done(3'b001);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
